game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 The block SHALL have a parameter START_LIVES, default 3, giving the lives loaded at game or level start (range 1..7).
REQ-002 The block SHALL have a parameter READY_FRAMES, default 120, giving the frame count spent in READY before play.
REQ-003 The block SHALL have a parameter DEATH_FRAMES, default 90, giving the frame count of the death freeze.
REQ-004 The block SHALL have a port clk, input, 1 bit: the single system clock.
REQ-005 The block SHALL have a port resetN, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have a port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-007 The block SHALL have a port start_key, input, 1 bit: level-sampled start button.
REQ-008 The block SHALL have a port pause_key, input, 1 bit: level-sampled pause button.
REQ-009 The block SHALL have a port pdot_exist, input, 1 bit: high while any pellet remains.
REQ-010 The block SHALL have a port edot_exist, input, 1 bit: high while any energizer remains.
REQ-011 The block SHALL have a port pacman_hit, input, 1 bit: ghost-collision indication.
REQ-012 The block SHALL have a port game_started, output, 1 bit: high during an active game.
REQ-013 The block SHALL have a port freeze, output, 1 bit: halts sprite motion.
REQ-014 The block SHALL have a port lives, output, 3 bits: remaining lives.
REQ-015 The block SHALL have a port game_won, output, 1 bit: win indication for the finish screen.
REQ-016 The block SHALL have a port game_lost, output, 1 bit: loss indication for the finish screen.
REQ-017 The block SHALL have a port respawn, output, 1 bit: one-cycle pulse that returns sprites to their start tiles.
REQ-018 The block SHALL have a port level_reset, output, 1 bit: one-cycle pulse that reloads the dots.

Function
REQ-019 The block SHALL register all outputs; every state-dependent output SHALL be valid in the cycle after the state register updates.
REQ-020 The block SHALL register start_key and pause_key and act only on their rising edges (rise = current high AND previous low).
REQ-021 The block SHALL implement the states IDLE, READY, PLAY, DYING, WON and LOST.
REQ-022 In IDLE, a start rise SHALL load lives=START_LIVES, pulse level_reset and respawn, and transition to READY.
REQ-023 READY SHALL go to PLAY on the READY_FRAMES-th frame_tick after entry, and DYING SHALL go to READY on the DEATH_FRAMES-th frame_tick after entry; a parameter value of 0 SHALL act as 1.
REQ-024 On every DYING->READY transition the block SHALL pulse respawn for one cycle.
REQ-025 In PLAY, if pdot_exist and edot_exist are both low, the block SHALL go to WON, with priority over a simultaneous pacman_hit.
REQ-026 In PLAY, pacman_hit without a win SHALL decrement lives; if lives was 1 the block SHALL go to LOST with lives=0, otherwise to DYING.
REQ-027 The block SHALL ignore pacman_hit outside PLAY; lives SHALL never underflow.
REQ-028 WON and LOST SHALL hold until a start rise, which SHALL perform the IDLE start action of REQ-022.
REQ-029 game_started SHALL be high in READY, PLAY, DYING and PAUSED; freeze SHALL be high in every state except PLAY.
REQ-030 game_won SHALL be high only in WON, and game_lost SHALL be high only in LOST; the two SHALL never be high together.
REQ-031 The frame timer SHALL be 8 bits wide; READY_FRAMES and DEATH_FRAMES SHALL be at most 255.
REQ-032 The frame timer SHALL reload on every state entry; a frame_tick coinciding with the state entry SHALL NOT count.

Reset
REQ-033 When resetN is low at a clk edge, the block SHALL set state=IDLE, lives=0, the timer and key history to 0, and all outputs to 0 except freeze=1.
REQ-034 Reset asserted mid-game SHALL take effect at the next edge, abandoning any count in progress, and SHALL emit no respawn or level_reset pulse.

Configuration
REQ-035 With the macro PAUSE_EN defined, the block SHALL add a PAUSED state: a pause rise moves PLAY->PAUSED and PAUSED->PLAY, and dots and hits SHALL be ignored while in PAUSED.
REQ-036 Without PAUSE_EN, pause_key SHALL remain a port but SHALL be ignored and no PAUSED state SHALL exist.

Structure
REQ-037 The package game_pkg SHALL hold the game_state_t enum, a LIVES_W=3 constant and a TIMER_W=8 constant.
REQ-038 The block SHALL instantiate one sub-module, frame_timer: a loadable down-counter decremented by frame_tick, with a done output.

Verification
REQ-039 Reset, then a start rise -> READY with lives=3 and one-cycle respawn and level_reset pulses; PLAY follows on frame_tick #120.
REQ-040 In PLAY, pacman_hit with lives=3 -> lives=2 and DYING; respawn pulses and READY is entered on frame_tick #90.
REQ-041 In PLAY with lives=1, pacman_hit -> LOST, lives=0, game_lost=1, freeze=1.
REQ-042 Both dot inputs dropping low in the same cycle as pacman_hit -> WON, lives unchanged, game_won=1.
REQ-043 In WON, a start rise -> READY, lives=3, level_reset pulse; holding start high produces no second action.
REQ-044 With PAUSE_EN, a pause rise in PLAY -> PAUSED and freeze=1, a hit is ignored, and a second pause rise -> PLAY; without PAUSE_EN the block stays in PLAY.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the game controller.
// Latency: n/a (types only). Backpressure: n/a.
// PAUSED exists in the state enum only when PAUSE_EN is defined.
package game_pkg;

    localparam int LIVES_W = 3;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        DYING = 3'd3,
        WON   = 3'd4,
        LOST  = 3'd5
`ifdef PAUSE_EN
        , PAUSED = 3'd6
`endif
    } game_state_t;

    typedef struct packed {
        logic game_started;
        logic freeze;
        logic game_won;
        logic game_lost;
    } status_t;

    // Status flags implied by a state; registered alongside the state itself.
    function automatic status_t state_status(game_state_t s);
        status_t st;
        st.game_started = (s == READY) || (s == PLAY) || (s == DYING);
`ifdef PAUSE_EN
        st.game_started = st.game_started || (s == PAUSED);
`endif
        st.freeze    = (s != PLAY);
        st.game_won  = (s == WON);
        st.game_lost = (s == LOST);
        return st;
    endfunction

endpackage

// File: rtl/game_controller_frame_timer.sv
// Loadable frame down-counter; done flags the tick that takes the count from 1 to 0.
// Latency: done is combinational on tick. Backpressure: none, every tick is consumed.
// A load cycle swallows any coincident tick.
module frame_timer
    import game_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = tick && !load && (cnt == W'(1));

endmodule

// File: rtl/game_controller.sv
// Game flow FSM: start, ready countdown, play, death freeze, win/lose; PAUSE_EN adds PAUSED.
// Latency: one clk from input to registered outputs. Backpressure: none, keys act on rising edges only.
// Counts are in frame_tick pulses; a zero frame parameter behaves as one.
module game_controller
    import game_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int READY_FRAMES = 120,
    parameter int DEATH_FRAMES = 90
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               frame_tick,
    input  logic               start_key,
    input  logic               pause_key,
    input  logic               pdot_exist,
    input  logic               edot_exist,
    input  logic               pacman_hit,
    output logic               game_started,
    output logic               freeze,
    output logic [LIVES_W-1:0] lives,
    output logic               game_won,
    output logic               game_lost,
    output logic               respawn,
    output logic               level_reset
);

    localparam logic [TIMER_W-1:0] READY_LD =
        (READY_FRAMES == 0) ? TIMER_W'(1) : TIMER_W'(READY_FRAMES);
    localparam logic [TIMER_W-1:0] DEATH_LD =
        (DEATH_FRAMES == 0) ? TIMER_W'(1) : TIMER_W'(DEATH_FRAMES);

    game_state_t        state;
    status_t            status;
    logic               start_prev;
    logic               pause_prev;
    logic               start_rise;
    logic               pause_rise;
    logic               timer_load;
    logic               timer_done;
    logic [TIMER_W-1:0] timer_val;

    assign start_rise = start_key && !start_prev;
    assign pause_rise = pause_key && !pause_prev;

`ifndef PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_rise;
`endif

    // The timer reloads in the first cycle of each new state, so it sees the new state here.
    assign timer_val = (state == DYING) ? DEATH_LD : READY_LD;

    frame_timer #(.W(TIMER_W)) u_frame_timer (
        .clk      (clk),
        .resetN   (resetN),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (frame_tick),
        .done     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            status      <= state_status(IDLE);
            lives       <= '0;
            start_prev  <= 1'b0;
            pause_prev  <= 1'b0;
            timer_load  <= 1'b0;
            respawn     <= 1'b0;
            level_reset <= 1'b0;
        end else begin
            start_prev  <= start_key;
            pause_prev  <= pause_key;
            timer_load  <= 1'b0;
            respawn     <= 1'b0;
            level_reset <= 1'b0;
            case (state)
                IDLE, WON, LOST: begin
                    if (start_rise) begin
                        state       <= READY;
                        status      <= state_status(READY);
                        timer_load  <= 1'b1;
                        lives       <= LIVES_W'(START_LIVES);
                        respawn     <= 1'b1;
                        level_reset <= 1'b1;
                    end
                end
                READY: begin
                    if (timer_done) begin
                        state      <= PLAY;
                        status     <= state_status(PLAY);
                        timer_load <= 1'b1;
                    end
                end
                PLAY: begin
                    // Clearing the board beats a same-cycle collision.
                    if (!pdot_exist && !edot_exist) begin
                        state      <= WON;
                        status     <= state_status(WON);
                        timer_load <= 1'b1;
                    end else if (pacman_hit) begin
                        timer_load <= 1'b1;
                        if (lives <= LIVES_W'(1)) begin
                            lives  <= '0;
                            state  <= LOST;
                            status <= state_status(LOST);
                        end else begin
                            lives  <= lives - LIVES_W'(1);
                            state  <= DYING;
                            status <= state_status(DYING);
                        end
                    end
`ifdef PAUSE_EN
                    else if (pause_rise) begin
                        state      <= PAUSED;
                        status     <= state_status(PAUSED);
                        timer_load <= 1'b1;
                    end
`endif
                end
                DYING: begin
                    if (timer_done) begin
                        state      <= READY;
                        status     <= state_status(READY);
                        timer_load <= 1'b1;
                        respawn    <= 1'b1;
                    end
                end
`ifdef PAUSE_EN
                PAUSED: begin
                    if (pause_rise) begin
                        state      <= PLAY;
                        status     <= state_status(PLAY);
                        timer_load <= 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    status     <= state_status(IDLE);
                    timer_load <= 1'b1;
                end
            endcase
        end
    end

    assign game_started = status.game_started;
    assign freeze       = status.freeze;
    assign game_won     = status.game_won;
    assign game_lost    = status.game_lost;

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with a queue of expected output snapshots.
module tb_game_controller;

    logic       clk = 1'b0;
    logic       resetN;
    logic       frame_tick;
    logic       start_key;
    logic       pause_key;
    logic       pdot_exist;
    logic       edot_exist;
    logic       pacman_hit;
    logic       game_started;
    logic       freeze;
    logic [2:0] lives;
    logic       game_won;
    logic       game_lost;
    logic       respawn;
    logic       level_reset;

    typedef struct packed {
        logic       gs;
        logic       fz;
        logic [2:0] lv;
        logic       gw;
        logic       gl;
        logic       rs;
        logic       lr;
    } snap_t;

    snap_t exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    game_controller dut (
        .clk          (clk),
        .resetN       (resetN),
        .frame_tick   (frame_tick),
        .start_key    (start_key),
        .pause_key    (pause_key),
        .pdot_exist   (pdot_exist),
        .edot_exist   (edot_exist),
        .pacman_hit   (pacman_hit),
        .game_started (game_started),
        .freeze       (freeze),
        .lives        (lives),
        .game_won     (game_won),
        .game_lost    (game_lost),
        .respawn      (respawn),
        .level_reset  (level_reset)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(logic gs, logic fz, logic [2:0] lv, logic gw, logic gl,
                                 logic rs, logic lr);
        snap_t s;
        s.gs = gs; s.fz = fz; s.lv = lv; s.gw = gw; s.gl = gl; s.rs = rs; s.lr = lr;
        return s;
    endfunction

    function automatic snap_t s_idle();
        return mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic snap_t s_ready(logic [2:0] lv);
        return mk(1'b1, 1'b1, lv, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic snap_t s_play(logic [2:0] lv);
        return mk(1'b1, 1'b0, lv, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic snap_t s_dying(logic [2:0] lv);
        return mk(1'b1, 1'b1, lv, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic snap_t s_start();
        return mk(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push the expectation for the inputs just driven, clock once, then score the DUT.
    task automatic expect_step(input string tag, input snap_t exp);
        snap_t obs;
        snap_t want;
        string t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        step();
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        obs  = {game_started, freeze, lives, game_won, game_lost, respawn, level_reset};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed gs=%b fz=%b lv=%0d gw=%b gl=%b rs=%b lr=%b expected gs=%b fz=%b lv=%0d gw=%b gl=%b rs=%b lr=%b",
                   t, obs.gs, obs.fz, obs.lv, obs.gw, obs.gl, obs.rs, obs.lr,
                   want.gs, want.fz, want.lv, want.gw, want.gl, want.rs, want.lr);
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    // Assumes the entry cycle of READY has already elapsed.
    task automatic ready_to_play(input logic [2:0] lv, input string tag);
        run_ticks(119);
        expect_step({tag, "_ready_hold"}, s_ready(lv));
        frame_tick = 1'b1;
        expect_step({tag, "_to_play"}, s_play(lv));
        frame_tick = 1'b0;
    endtask

    // Hit in PLAY, hit ignored in DYING, then freeze ends on tick 90 with a respawn pulse.
    task automatic die_once(input logic [2:0] lv_after, input string tag);
        pacman_hit = 1'b1;
        expect_step({tag, "_hit"}, s_dying(lv_after));
        expect_step({tag, "_hit_in_dying"}, s_dying(lv_after));
        pacman_hit = 1'b0;
        run_ticks(89);
        expect_step({tag, "_dying_hold"}, s_dying(lv_after));
        frame_tick = 1'b1;
        expect_step({tag, "_respawn"}, mk(1'b1, 1'b1, lv_after, 1'b0, 1'b0, 1'b1, 1'b0));
        frame_tick = 1'b0;
        expect_step({tag, "_respawn_end"}, s_ready(lv_after));
    endtask

    initial begin
        resetN     = 1'b0;
        frame_tick = 1'b0;
        start_key  = 1'b0;
        pause_key  = 1'b0;
        pdot_exist = 1'b1;
        edot_exist = 1'b1;
        pacman_hit = 1'b0;
        step();
        expect_step("reset", s_idle());
        resetN = 1'b1;
        pacman_hit = 1'b1;
        expect_step("idle_hit_ignored", s_idle());
        pacman_hit = 1'b0;

        start_key = 1'b1;
        expect_step("start", s_start());
        // Entry cycle: this tick must not count toward the 120.
        frame_tick = 1'b1;
        expect_step("start_hold", s_ready(3'd3));
        frame_tick = 1'b0;
        start_key  = 1'b0;
        ready_to_play(3'd3, "first");

        die_once(3'd2, "death1");
        ready_to_play(3'd2, "second");
        die_once(3'd1, "death2");
        ready_to_play(3'd1, "third");

        pacman_hit = 1'b1;
        expect_step("lost", mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        expect_step("lost_hit_no_underflow", mk(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        pacman_hit = 1'b0;

        start_key = 1'b1;
        expect_step("restart_from_lost", s_start());
        expect_step("restart_entry", s_ready(3'd3));
        start_key = 1'b0;
        ready_to_play(3'd3, "fourth");

        pause_key = 1'b1;
`ifdef PAUSE_EN
        expect_step("pause", s_ready(3'd3));
        pacman_hit = 1'b1;
        pdot_exist = 1'b0;
        edot_exist = 1'b0;
        expect_step("paused_ignore", s_ready(3'd3));
        pacman_hit = 1'b0;
        pdot_exist = 1'b1;
        edot_exist = 1'b1;
        pause_key  = 1'b0;
        expect_step("paused_release", s_ready(3'd3));
        pause_key = 1'b1;
        expect_step("unpause", s_play(3'd3));
`else
        expect_step("pause_ignored", s_play(3'd3));
        pause_key = 1'b0;
        expect_step("pause_release", s_play(3'd3));
        pause_key = 1'b1;
        expect_step("pause_ignored2", s_play(3'd3));
`endif
        pause_key = 1'b0;

        pdot_exist = 1'b0;
        expect_step("pdot_only_low", s_play(3'd3));
        pdot_exist = 1'b1;
        edot_exist = 1'b0;
        expect_step("edot_only_low", s_play(3'd3));
        pdot_exist = 1'b0;
        pacman_hit = 1'b1;
        expect_step("win_beats_hit", mk(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        pacman_hit = 1'b0;
        pdot_exist = 1'b1;
        edot_exist = 1'b1;
        expect_step("won_hold", mk(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0));

        start_key = 1'b1;
        expect_step("restart_from_won", s_start());
        expect_step("start_held_1", s_ready(3'd3));
        expect_step("start_held_2", s_ready(3'd3));

        run_ticks(10);
        resetN = 1'b0;
        expect_step("midgame_reset", s_idle());
        resetN    = 1'b1;
        start_key = 1'b0;
        expect_step("after_reset_idle", s_idle());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
